// File: rtl/otsu_thresh_core_pkg.sv
// otsu_pkg: shared width derivations and FSM state encoding for the Otsu
// between-class-variance evaluator (otsu_thresh_core, otsu_sigma_dp,
// otsu_thresh_core_if). No ports.
package otsu_pkg;

  // Count width after dropping the low N_SHIFT bits of the raw counts.
  function automatic int calc_nw(input int cnt_w, input int n_shift);
    return cnt_w - n_shift;
  endfunction

  // sigma = (N1*N2) * d^2 needs two 2*NW products multiplied together.
  function automatic int calc_sig_w(input int nw);
    return 4 * nw;
  endfunction

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DIV1 = 3'd1;
  localparam logic [2:0] ST_DIV2 = 3'd2;
  localparam logic [2:0] ST_SUB  = 3'd3;
  localparam logic [2:0] ST_SQ   = 3'd4;
  localparam logic [2:0] ST_SIG  = 3'd5;
  localparam logic [2:0] ST_CMP  = 3'd6;
  localparam logic [2:0] ST_EMIT = 3'd7;

endpackage

// File: rtl/otsu_thresh_core_if.sv
// otsu_thresh_core_if: candidate stream (valid/ready) and result bus of the
// Otsu evaluator. master = candidate producer / result consumer,
// slave = otsu_thresh_core.
interface otsu_thresh_core_if #(
  parameter int GRAY_BITS = 7,
  parameter int CNT_W     = 20,
  parameter int SUM_W     = 23,
  parameter int N_SHIFT   = 4
);
  localparam int NW = otsu_pkg::calc_nw(CNT_W, N_SHIFT);
  localparam int SW = otsu_pkg::calc_sig_w(NW);

  logic                 cand_vld;
  logic                 cand_rdy;
  logic [CNT_W-1:0]     n1;
  logic [CNT_W-1:0]     n2;
  logic [SUM_W-1:0]     ga1;
  logic [SUM_W-1:0]     ga2;
  logic                 frame_end;
  logic                 thr_vld;
  logic [GRAY_BITS-1:0] thr_out;
  logic [SW-1:0]        sigma_max_out;

  modport master (
    output cand_vld, n1, n2, ga1, ga2, frame_end,
    input  cand_rdy, thr_vld, thr_out, sigma_max_out
  );

  modport slave (
    input  cand_vld, n1, n2, ga1, ga2, frame_end,
    output cand_rdy, thr_vld, thr_out, sigma_max_out
  );

endinterface

// File: rtl/otsu_sigma_dp.sv
// otsu_sigma_dp: shared combinational datapath (one divider, one multiplier,
// one saturating subtractor) whose operands are selected by the core's FSM state.
// Ports: state_i selects operands; n*/ga*/mu*/d/nn/sq are the core's registers;
// quot_o = mean, dsat_o = |mu1-mu2| saturated, prod_o = product. Macro: OTSU_ROUND_DIV_EN.
module otsu_sigma_dp
  import otsu_pkg::*;
#(
  parameter int NW    = 16,
  parameter int SUM_W = 23
) (
  input  logic [2:0]       state_i,
  input  logic [NW-1:0]    n1_i,
  input  logic [NW-1:0]    n2_i,
  input  logic [SUM_W-1:0] ga1_i,
  input  logic [SUM_W-1:0] ga2_i,
  input  logic [SUM_W-1:0] mu1_i,
  input  logic [SUM_W-1:0] mu2_i,
  input  logic [NW-1:0]    d_i,
  input  logic [2*NW-1:0]  nn_i,
  input  logic [2*NW-1:0]  sq_i,
  output logic [SUM_W-1:0] quot_o,
  output logic [NW-1:0]    dsat_o,
  output logic [4*NW-1:0]  prod_o
);
  // One extra bit so the rounding bias cannot overflow the numerator.
  localparam int DIVW = (SUM_W + 1 > NW) ? SUM_W + 1 : NW;
  localparam int DW   = (SUM_W > NW) ? SUM_W : NW;
  localparam int MW   = 4 * NW;

  logic [DIVW-1:0] num_w;
  logic [DIVW-1:0] den_w;
  logic [DIVW-1:0] q_w;

  always_comb begin
    num_w = DIVW'(ga1_i);
    den_w = DIVW'(n1_i);
    if (state_i == ST_DIV2) begin
      num_w = DIVW'(ga2_i);
      den_w = DIVW'(n2_i);
    end
`ifdef OTSU_ROUND_DIV_EN
    num_w = num_w + (den_w >> 1);
`endif
    q_w = '0;
    if (den_w != '0) q_w = num_w / den_w;
  end

  // The quotient always fits SUM_W bits; the clamp only keeps the top bits live.
  assign quot_o = (|q_w[DIVW-1:SUM_W]) ? {SUM_W{1'b1}} : q_w[SUM_W-1:0];

  logic [SUM_W-1:0] diff;
  logic [DW-1:0]    diff_w;

  assign diff   = (mu1_i >= mu2_i) ? (mu1_i - mu2_i) : (mu2_i - mu1_i);
  assign diff_w = DW'(diff);
  assign dsat_o = (diff_w > DW'({NW{1'b1}})) ? {NW{1'b1}} : diff_w[NW-1:0];

  // DIV1: N1*N2, SQ: d*d, SIG: (N1*N2)*sq. Operands are < 2^(2*NW), so a
  // 4*NW result is exact.
  logic [MW-1:0] ma;
  logic [MW-1:0] mb;

  always_comb begin
    ma = MW'(n1_i);
    mb = MW'(n2_i);
    if (state_i == ST_SQ) begin
      ma = MW'(d_i);
      mb = MW'(d_i);
    end else if (state_i == ST_SIG) begin
      ma = MW'(nn_i);
      mb = MW'(sq_i);
    end
  end

  assign prod_o = ma * mb;

endmodule

// File: rtl/otsu_thresh_core.sv
// otsu_thresh_core: per-candidate Otsu sigma = N1*N2*(mu1-mu2)^2, running arg-max,
// result pulse on frame end. Ports: clock, rst_n (async, active-low), bus
// (otsu_thresh_core_if.slave). One candidate per 7 cycles; cand_rdy only in IDLE
// and never after 2**GRAY_BITS candidates until the result is emitted.
// Macro: OTSU_ROUND_DIV_EN selects round-to-nearest means (default truncating).
module otsu_thresh_core
  import otsu_pkg::*;
#(
  parameter int GRAY_BITS = 7,
  parameter int CNT_W     = 20,
  parameter int SUM_W     = 23,
  parameter int N_SHIFT   = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  otsu_thresh_core_if.slave bus
);
  localparam int NW = calc_nw(CNT_W, N_SHIFT);
  localparam int SW = calc_sig_w(NW);
  localparam int PW = 2 * NW;

  logic [2:0]           state_q, state_d;
  logic [NW-1:0]        n1_q, n1_d, n2_q, n2_d;
  logic [SUM_W-1:0]     ga1_q, ga1_d, ga2_q, ga2_d;
  logic [SUM_W-1:0]     mu1_q, mu1_d, mu2_q, mu2_d;
  logic [NW-1:0]        dif_q, dif_d;
  logic [PW-1:0]        nn_q, nn_d, sq_q, sq_d;
  logic [SW-1:0]        sig_q, sig_d, max_q, max_d, sig_out_q, sig_out_d;
  logic [GRAY_BITS-1:0] tmax_q, tmax_d, thr_out_q, thr_out_d;
  // Extra MSB marks "2**GRAY_BITS candidates taken"; the index never wraps.
  logic [GRAY_BITS:0]   idx_q, idx_d;
  logic                 pend_q, pend_d, thr_vld_q, thr_vld_d;

  logic [SUM_W-1:0]     quot;
  logic [NW-1:0]        dsat;
  logic [SW-1:0]        prod;
  logic                 rdy;
  logic                 accept;

  assign rdy    = (state_q == ST_IDLE) && !idx_q[GRAY_BITS];
  assign accept = bus.cand_vld && rdy;

  assign bus.cand_rdy      = rdy;
  assign bus.thr_vld       = thr_vld_q;
  assign bus.thr_out       = thr_out_q;
  assign bus.sigma_max_out = sig_out_q;

  otsu_sigma_dp #(
    .NW    (NW),
    .SUM_W (SUM_W)
  ) u_dp (
    .state_i (state_q),
    .n1_i    (n1_q),
    .n2_i    (n2_q),
    .ga1_i   (ga1_q),
    .ga2_i   (ga2_q),
    .mu1_i   (mu1_q),
    .mu2_i   (mu2_q),
    .d_i     (dif_q),
    .nn_i    (nn_q),
    .sq_i    (sq_q),
    .quot_o  (quot),
    .dsat_o  (dsat),
    .prod_o  (prod)
  );

  always_comb begin
    state_d   = state_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    ga1_d     = ga1_q;
    ga2_d     = ga2_q;
    mu1_d     = mu1_q;
    mu2_d     = mu2_q;
    dif_d     = dif_q;
    nn_d      = nn_q;
    sq_d      = sq_q;
    sig_d     = sig_q;
    max_d     = max_q;
    tmax_d    = tmax_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    thr_vld_d = 1'b0;
    thr_out_d = thr_out_q;
    sig_out_d = sig_out_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          n1_d    = bus.n1[CNT_W-1:N_SHIFT];
          n2_d    = bus.n2[CNT_W-1:N_SHIFT];
          ga1_d   = bus.ga1;
          ga2_d   = bus.ga2;
          pend_d  = bus.frame_end;
          state_d = ST_DIV1;
        end else if (bus.frame_end) begin
          state_d = ST_EMIT;
        end
      end
      ST_DIV1: begin
        mu1_d   = quot;
        nn_d    = prod[PW-1:0];
        state_d = ST_DIV2;
      end
      ST_DIV2: begin
        mu2_d   = quot;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        dif_d   = dsat;
        state_d = ST_SQ;
      end
      ST_SQ: begin
        sq_d    = prod[PW-1:0];
        state_d = ST_SIG;
      end
      ST_SIG: begin
        sig_d   = prod;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        // Strict compare: on a tie the earlier threshold is kept.
        if (sig_q > max_q) begin
          max_d  = sig_q;
          tmax_d = idx_q[GRAY_BITS-1:0];
        end
        idx_d   = idx_q + 1'b1;
        // A frame_end arriving in this very cycle still closes the frame.
        state_d = (pend_q || bus.frame_end) ? ST_EMIT : ST_IDLE;
      end
      default: begin  // ST_EMIT
        thr_vld_d = 1'b1;
        thr_out_d = tmax_q;
        sig_out_d = max_q;
        max_d     = '0;
        tmax_d    = '0;
        idx_d     = '0;
        pend_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (bus.frame_end && (state_q >= ST_DIV1) && (state_q <= ST_SIG)) pend_d = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n1_q      <= '0;
      n2_q      <= '0;
      ga1_q     <= '0;
      ga2_q     <= '0;
      mu1_q     <= '0;
      mu2_q     <= '0;
      dif_q     <= '0;
      nn_q      <= '0;
      sq_q      <= '0;
      sig_q     <= '0;
      max_q     <= '0;
      tmax_q    <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      thr_vld_q <= 1'b0;
      thr_out_q <= '0;
      sig_out_q <= '0;
    end else begin
      state_q   <= state_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      ga1_q     <= ga1_d;
      ga2_q     <= ga2_d;
      mu1_q     <= mu1_d;
      mu2_q     <= mu2_d;
      dif_q     <= dif_d;
      nn_q      <= nn_d;
      sq_q      <= sq_d;
      sig_q     <= sig_d;
      max_q     <= max_d;
      tmax_q    <= tmax_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      thr_vld_q <= thr_vld_d;
      thr_out_q <= thr_out_d;
      sig_out_q <= sig_out_d;
    end
  end

endmodule

// File: tb/tb_otsu_thresh_core.sv
// tb_otsu_thresh_core: directed table, multi-cycle corner sequences and random
// frames checked against a plain-arithmetic Otsu reference model.
module tb_otsu_thresh_core;
  localparam int GB = 7;
  localparam int CW = 20;
  localparam int SM = 23;
  localparam int NS = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  otsu_thresh_core_if #(.GRAY_BITS(GB), .CNT_W(CW), .SUM_W(SM), .N_SHIFT(NS)) bus ();

  otsu_thresh_core #(.GRAY_BITS(GB), .CNT_W(CW), .SUM_W(SM), .N_SHIFT(NS)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [19:0] n1;
    logic [19:0] n2;
    logic [22:0] ga1;
    logic [22:0] ga2;
    logic        eof;
    logic [6:0]  thr;
    logic [63:0] sig;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mean(input logic [22:0] ga, input logic [63:0] cnt);
    if (cnt == 0) return 64'd0;
`ifdef OTSU_ROUND_DIV_EN
    return (64'(ga) + cnt / 2) / cnt;
`else
    return 64'(ga) / cnt;
`endif
  endfunction

  function automatic logic [63:0] ref_sigma(input logic [19:0] n1, input logic [19:0] n2,
                                            input logic [22:0] ga1, input logic [22:0] ga2);
    logic [63:0] c1, c2, m1, m2, d;
    c1 = 64'(n1) / 16;
    c2 = 64'(n2) / 16;
    m1 = ref_mean(ga1, c1);
    m2 = ref_mean(ga2, c2);
    d  = (m1 > m2) ? m1 - m2 : m2 - m1;
    if (d > 64'd65535) d = 64'd65535;
    return c1 * c2 * d * d;
  endfunction

  function automatic logic [19:0] rnd_cnt();
    case ($urandom_range(0, 3))
      0:       return 20'($urandom_range(0, 15));
      1:       return 20'($urandom_range(16, 4095));
      default: return 20'($urandom_range(0, 20'hFFFFF));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [19:0] a, input logic [19:0] b, input logic [22:0] c,
                      input logic [22:0] d, input bit fe, output int c0);
    int w;
    w = 0;
    while (bus.cand_rdy !== 1'b1 && w < 60) begin
      @(negedge clock);
      w++;
    end
    if (bus.cand_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_rdy_timeout: cand_rdy=%0b, expected 1 within 60 cycles", bus.cand_rdy);
    end
    bus.cand_vld  = 1'b1;
    bus.n1        = a;
    bus.n2        = b;
    bus.ga1       = c;
    bus.ga2       = d;
    bus.frame_end = fe;
    @(negedge clock);
    bus.cand_vld  = 1'b0;
    bus.frame_end = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // elat: expected cycles from the accept (or frame_end) cycle to thr_vld; 0 = unchecked.
  task automatic wait_thr(input string nm, input logic [6:0] et, input logic [63:0] es,
                          input int elat, input int c0);
    int w;
    w = 0;
    while (bus.thr_vld !== 1'b1 && w < 40) begin
      @(negedge clock);
      w++;
    end
    if (bus.thr_vld !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: thr_vld=%0b, expected 1 within 40 cycles", nm, bus.thr_vld);
    end else begin
      if (elat > 0) chk({nm, "_lat"}, 64'(cyc - c0 + 1), 64'(elat));
      chk({nm, "_thr"}, 64'(bus.thr_out), 64'(et));
      chk({nm, "_sig"}, bus.sigma_max_out, es);
      @(negedge clock);
      chk({nm, "_pulse"}, 64'(bus.thr_vld), 64'd0);
      chk({nm, "_hold"}, 64'(bus.thr_out), 64'(et));
    end
  endtask

  initial begin
    int c0;
    int bad;
    int nc;
    int bi;
    bit sep;
    logic [63:0] best;
    logic [63:0] s;
    logic [19:0] ra, rb;
    logic [22:0] rc, rd;

    // n1, n2, ga1, ga2, eof, expected thr, expected sigma
    tbl[0] = '{20'd160, 20'd16,  23'd10,      23'd0,    1'b0, 7'd0, 64'd0};
    tbl[1] = '{20'd800, 20'd16,  23'd50,      23'd0,    1'b0, 7'd0, 64'd0};
    tbl[2] = '{20'd800, 20'd16,  23'd50,      23'd0,    1'b1, 7'd1, 64'd50};
    tbl[3] = '{20'd16,  20'd16,  23'd5,       23'd5,    1'b0, 7'd0, 64'd0};
    tbl[4] = '{20'd0,   20'd160, 23'd999,     23'd5000, 1'b1, 7'd0, 64'd0};
    tbl[5] = '{20'd320, 20'd160, 23'd2000,    23'd5000, 1'b1, 7'd0, 64'd32000000};
    tbl[6] = '{20'd16,  20'd16,  23'd8000000, 23'd0,    1'b1, 7'd0, 64'd4294836225};

    bus.cand_vld  = 1'b0;
    bus.n1        = '0;
    bus.n2        = '0;
    bus.ga1       = '0;
    bus.ga2       = '0;
    bus.frame_end = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_cand_rdy", 64'(bus.cand_rdy), 64'd1);
    chk("rst_thr_vld", 64'(bus.thr_vld), 64'd0);
    chk("rst_thr_out", 64'(bus.thr_out), 64'd0);
    chk("rst_sigma", bus.sigma_max_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].n1, tbl[i].n2, tbl[i].ga1, tbl[i].ga2, tbl[i].eof, c0);
      if (tbl[i].eof) wait_thr($sformatf("tbl%0d", i), tbl[i].thr, tbl[i].sig, 8, c0);
    end

    // Throughput: busy for 6 cycles after accept, ready again in cycle 7.
    send(20'd320, 20'd160, 23'd2000, 23'd5000, 1'b0, c0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("rdy_cyc%0d", k), 64'(bus.cand_rdy), (k == 7) ? 64'd1 : 64'd0);
      if (k < 7) @(negedge clock);
    end
    bus.frame_end = 1'b1;
    @(negedge clock);
    bus.frame_end = 1'b0;
    c0 = cyc;
    wait_thr("idle_fe", 7'd0, 64'd32000000, 2, c0);

    // frame_end while in SQ; then the next frame starts from index 0, max 0.
    send(20'd800, 20'd16, 23'd50, 23'd0, 1'b0, c0);
    wait_until(c0 + 3);
    bus.frame_end = 1'b1;
    @(negedge clock);
    bus.frame_end = 1'b0;
    wait_thr("fe_in_sq", 7'd0, 64'd50, 8, c0);
    send(20'd160, 20'd16, 23'd10, 23'd0, 1'b1, c0);
    wait_thr("after_sq", 7'd0, 64'd10, 8, c0);

    // Empty frame.
    bus.frame_end = 1'b1;
    @(negedge clock);
    bus.frame_end = 1'b0;
    c0 = cyc;
    wait_thr("empty", 7'd0, 64'd0, 2, c0);

    // Index overflow: 128 accepted, the 129th must be refused until EMIT.
    for (int i = 0; i < 128; i++) begin
      if (i == 5) send(20'd800, 20'd16, 23'd50, 23'd0, 1'b0, c0);
      else        send(20'd16, 20'd16, 23'd5, 23'd5, 1'b0, c0);
    end
    bus.cand_vld = 1'b1;
    bus.n1       = 20'd16;
    bus.n2       = 20'd16;
    bus.ga1      = 23'd8000000;
    bus.ga2      = 23'd0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cand_rdy !== 1'b0) bad++;
      @(negedge clock);
    end
    chk("ovf_rdy_low", 64'(bad), 64'd0);
    bus.cand_vld  = 1'b0;
    bus.frame_end = 1'b1;
    @(negedge clock);
    bus.frame_end = 1'b0;
    c0 = cyc;
    wait_thr("ovf", 7'd5, 64'd50, 2, c0);
    chk("ovf_rdy_back", 64'(bus.cand_rdy), 64'd1);

    // Reset in SIG with a pending frame_end: no result, clean restart.
    send(20'd160, 20'd16, 23'd10, 23'd0, 1'b0, c0);
    wait_until(c0 + 1);
    bus.frame_end = 1'b1;
    @(negedge clock);
    bus.frame_end = 1'b0;
    wait_until(c0 + 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_cand_rdy", 64'(bus.cand_rdy), 64'd1);
    chk("midrst_thr_vld", 64'(bus.thr_vld), 64'd0);
    chk("midrst_thr_out", 64'(bus.thr_out), 64'd0);
    chk("midrst_sigma", bus.sigma_max_out, 64'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.thr_vld !== 1'b0) bad++;
    end
    chk("midrst_no_vld", 64'(bad), 64'd0);
    send(20'd16, 20'd16, 23'd5, 23'd5, 1'b0, c0);
    send(20'd160, 20'd16, 23'd10, 23'd0, 1'b1, c0);
    wait_thr("post_rst", 7'd1, 64'd10, 8, c0);

    // Random frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      nc   = $urandom_range(1, 8);
      sep  = 1'($urandom_range(0, 1));
      best = 64'd0;
      bi   = 0;
      for (int i = 0; i < nc; i++) begin
        ra = rnd_cnt();
        rb = rnd_cnt();
        rc = 23'($urandom_range(0, 23'h7FFFFF));
        rd = 23'($urandom_range(0, 23'h7FFFFF));
        s  = ref_sigma(ra, rb, rc, rd);
        if (s > best) begin
          best = s;
          bi   = i;
        end
        send(ra, rb, rc, rd, !sep && (i == nc - 1), c0);
      end
      if (sep) begin
        repeat ($urandom_range(0, 10)) @(negedge clock);
        bus.frame_end = 1'b1;
        @(negedge clock);
        bus.frame_end = 1'b0;
      end
      wait_thr($sformatf("rnd%0d", f), 7'(bi), best, 0, c0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule
